// File: rtl/mau_copy_master.sv
// rtl/mau_copy_master.sv - bus-initiator block copy engine for the MAU single-word memory bus
module mau_copy_master #(
    parameter int TIMEOUT = 255,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      bus_address,
    output logic             bus_bus_enable,
    output logic [3:0]       bus_byte_enable,
    output logic             bus_rw,
    output logic [31:0]      bus_write_data,
    input  logic [31:0]      bus_read_data,
    input  logic             bus_acknowledge
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_FIN
    } state_t;

    // The watchdog fires when the TIMEOUT-th enable cycle passes with no ack,
    // i.e. when the cycle counter already reads TIMEOUT-1 and ack is still low.
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state;
    state_t           state_d;
    logic [31:0]      src_q;
    logic [31:0]      src_d;
    logic [31:0]      dst_q;
    logic [31:0]      dst_d;
    logic [31:0]      data_q;
    logic [31:0]      data_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic [15:0]      tmo_q;
    logic [15:0]      tmo_d;
    logic             done_d;
    logic             error_d;
    logic             access_d;

    // Next-state, pointer/count/data updates and completion strobes.
    always_comb begin
        state_d = state;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    rem_d = cmd_len;
                    if ((cmd_src[1:0] != 2'b00) || (cmd_dst[1:0] != 2'b00)) begin
                        // Misaligned requests never touch the bus.
                        state_d = S_FIN;
                        error_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                        tmo_d   = '0;
                    end
                end
            end
            S_RD: begin
                // Ack wins over the watchdog on the last allowed cycle.
                if (bus_acknowledge) begin
                    data_d  = bus_read_data;
                    state_d = S_RD_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FIN;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RD_GAP: begin
                state_d = S_WR;
                tmo_d   = '0;
            end
            S_WR: begin
                if (bus_acknowledge) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    rem_d   = rem_q - LEN_ONE;
                    state_d = S_WR_GAP;
                    // done is registered, so it shows during the WR_GAP cycle
                    // that observes the count reaching zero.
                    done_d  = (rem_q == LEN_ONE);
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FIN;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WR_GAP: begin
                if (rem_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RD;
                    tmo_d   = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign access_d = (state_d == S_RD) || (state_d == S_WR);

    // State, working registers and registered bus/status outputs; the outputs are
    // derived from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            src_q           <= '0;
            dst_q           <= '0;
            data_q          <= '0;
            rem_q           <= '0;
            tmo_q           <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            bus_address     <= '0;
            bus_bus_enable  <= 1'b0;
            bus_byte_enable <= 4'b0000;
            bus_rw          <= 1'b0;
            bus_write_data  <= '0;
        end else begin
            state           <= state_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            data_q          <= data_d;
            rem_q           <= rem_d;
            tmo_q           <= tmo_d;
            cmd_ready       <= (state_d == S_IDLE);
            busy            <= (state_d != S_IDLE);
            done            <= done_d;
            error           <= error_d;
            bus_bus_enable  <= access_d;
            bus_byte_enable <= access_d ? 4'b1111 : 4'b0000;
            bus_rw          <= (state_d == S_RD);
            // Address and data only change when an access is being set up, so
            // they hold steady for the whole enable-high interval.
            if (state_d == S_RD) begin
                bus_address <= src_d;
            end else if (state_d == S_WR) begin
                bus_address <= dst_d;
            end
            if (state_d == S_WR) begin
                bus_write_data <= data_d;
            end
        end
    end

endmodule

// File: tb/tb_mau_copy_master.sv
// tb/tb_mau_copy_master.sv - randomized model-checked bench for mau_copy_master
module tb_mau_copy_master;

    localparam int TO = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_src;
    logic [31:0]   cmd_dst;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   bus_address;
    logic          bus_bus_enable;
    logic [3:0]    bus_byte_enable;
    logic          bus_rw;
    logic [31:0]   bus_write_data;
    logic [31:0]   bus_read_data;
    logic          bus_acknowledge;

    always #5 clk = ~clk;

    mau_copy_master #(.TIMEOUT(TO), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .busy(busy), .done(done), .error(error),
        .bus_address(bus_address), .bus_bus_enable(bus_bus_enable),
        .bus_byte_enable(bus_byte_enable), .bus_rw(bus_rw),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
        .bus_acknowledge(bus_acknowledge)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
    } acc_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected behaviour: a queue of bus accesses still owed, plus the cycles at
    // which the next access, done, error and cmd_ready are due.
    acc_t pend[$];
    int   next_en   = 0;
    int   done_cyc  = -1;
    int   err_cyc   = -1;
    int   ready_cyc = 0;
    int   en_cnt    = 0;

    // Slave memory and observation log.
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] log_addr[$];
    logic        log_rw[$];
    logic [31:0] log_data[$];
    int ack_mode  = 1;
    int ack_tgt   = 0;
    int slave_cnt = 0;
    int acc0      = 0;
    int seen_done = -1;
    int seen_err  = -1;
    int seen_rdy  = -1;
    int en_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_done"}, 32'(done), 32'd0);
        chk({p, "_error"}, 32'(error), 32'd0);
        chk({p, "_en"}, 32'(bus_bus_enable), 32'd0);
        chk({p, "_be"}, 32'(bus_byte_enable), 32'd0);
        chk({p, "_rw"}, 32'(bus_rw), 32'd0);
        chk({p, "_addr"}, bus_address, 32'd0);
        chk({p, "_wdata"}, bus_write_data, 32'd0);
    endtask

    function automatic int pick_target();
        int r;
        case (ack_mode)
            0: return int'($urandom_range(1, 4));
            1: return 2;
            2: return 0;
            3: return TO;
            default: begin
                r = int'($urandom_range(0, 11));
                if (r == 0) return 0;
                if (r == 1) return TO;
                return int'($urandom_range(1, 3));
            end
        endcase
    endfunction

    // Compare process and bus slave, once per cycle at the falling edge.
    logic        m_en;
    logic        m_rdy;
    logic        m_ack;
    logic [31:0] m_a;
    logic [31:0] m_d;
    acc_t        m_e;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk_reset_vals("rst");
            pend.delete();
            done_cyc        = -1;
            err_cyc         = -1;
            ready_cyc       = 0;
            en_cnt          = 0;
            slave_cnt       = 0;
            bus_acknowledge = 1'b0;
        end else begin
            m_rdy = (cyc >= ready_cyc);
            m_en  = (pend.size() > 0) && (cyc >= next_en);
            chk("ready", 32'(cmd_ready), 32'(m_rdy));
            chk("busy", 32'(busy), 32'(!m_rdy));
            chk("done", 32'(done), 32'(cyc == done_cyc));
            chk("error", 32'(error), 32'(cyc == err_cyc));
            chk("enable", 32'(bus_bus_enable), 32'(m_en));
            chk("byte_en", 32'(bus_byte_enable), m_en ? 32'hF : 32'h0);
            if (m_en) begin
                chk("address", bus_address, pend[0].addr);
                chk("rw", 32'(bus_rw), 32'(pend[0].rw));
                if (!pend[0].rw) chk("wdata", bus_write_data, pend[0].wdata);
            end
            if (bus_bus_enable) en_cycles++;
            if (done && seen_done < 0) seen_done = cyc - acc0;
            if (error && seen_err < 0) seen_err = cyc - acc0;
            if (cmd_ready && seen_rdy < 0 && cyc > acc0) seen_rdy = cyc - acc0;

            m_ack = 1'b0;
            if (bus_bus_enable) begin
                if (slave_cnt == 0) ack_tgt = pick_target();
                slave_cnt++;
                if (ack_tgt != 0 && slave_cnt == ack_tgt) begin
                    m_ack     = 1'b1;
                    slave_cnt = 0;
                    if (bus_rw) begin
                        m_d = mem.exists(bus_address) ? mem[bus_address] : init_val(bus_address);
                        bus_read_data = m_d;
                    end else begin
                        m_d = bus_write_data;
                        mem[bus_address] = m_d;
                    end
                    log_addr.push_back(bus_address);
                    log_rw.push_back(bus_rw);
                    log_data.push_back(m_d);
                end else begin
                    bus_read_data = $urandom;
                end
            end else begin
                slave_cnt     = 0;
                m_ack         = ($urandom_range(0, 3) == 0);
                bus_read_data = $urandom;
            end
            bus_acknowledge = m_ack;

            if (m_en) begin
                if (m_ack) begin
                    void'(pend.pop_front());
                    en_cnt  = 0;
                    next_en = cyc + 2;
                    if (pend.size() == 0) begin
                        done_cyc  = cyc + 1;
                        ready_cyc = cyc + 3;
                    end
                end else begin
                    en_cnt++;
                    if (en_cnt == TO) begin
                        pend.delete();
                        en_cnt    = 0;
                        err_cyc   = cyc + 1;
                        ready_cyc = cyc + 2;
                    end
                end
            end

            if (cmd_valid && m_rdy) begin
                acc0      = cyc;
                seen_done = -1;
                seen_err  = -1;
                seen_rdy  = -1;
                if (cmd_src[1:0] != 2'b00 || cmd_dst[1:0] != 2'b00) begin
                    err_cyc   = cyc + 1;
                    ready_cyc = cyc + 2;
                end else if (cmd_len == '0) begin
                    done_cyc  = cyc + 1;
                    ready_cyc = cyc + 2;
                end else begin
                    refm = mem;
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        m_a = cmd_src + 32'(4 * i);
                        m_d = refm.exists(m_a) ? refm[m_a] : init_val(m_a);
                        m_e.addr = m_a; m_e.rw = 1'b1; m_e.wdata = 32'h0;
                        pend.push_back(m_e);
                        m_a = cmd_dst + 32'(4 * i);
                        m_e.addr = m_a; m_e.rw = 1'b0; m_e.wdata = m_d;
                        pend.push_back(m_e);
                        refm[m_a] = m_d;
                    end
                    next_en   = cyc + 1;
                    ready_cyc = 32'h3FFF_FFFF;
                    en_cnt    = 0;
                end
            end
        end
    end

    task automatic wait_ready(input string nm);
        int k = 0;
        while (!cmd_ready && k < 5000) begin
            @(posedge clk); #2;
            k++;
        end
        chk(nm, 32'(k < 5000), 32'd1);
    endtask

    task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l);
        wait_ready("start_wait");
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l;
        @(posedge clk); #2;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_src   = $urandom;
        cmd_dst   = $urandom;
        cmd_len   = LW'($urandom);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l);
        start_cmd(s, d, l);
        wait_ready("idle_wait");
        repeat (2) begin @(posedge clk); #2; end
    endtask

    logic [31:0] ex_a [6];
    logic        ex_r [6];
    logic [31:0] ex_d [6];
    int lsz;
    int e0;
    logic [31:0] rs;
    logic [31:0] rd;
    int r;
    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
        bus_acknowledge = 1'b0; bus_read_data = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Three-word copy with a 1-cycle-ack slave.
        ack_mode = 1;
        mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1; mem[32'h108] = 32'hA2;
        ex_a = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
        ex_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ex_d = '{32'hA0, 32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA2};
        lsz = log_addr.size();
        run_cmd(32'h100, 32'h200, 3);
        chk("copy_done_cycle", 32'(seen_done), 32'd18);
        chk("copy_ready_cycle", 32'(seen_rdy), 32'd20);
        chk("copy_n_access", 32'(log_addr.size() - lsz), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (lsz + i < log_addr.size()) begin
                chk("copy_seq_addr", log_addr[lsz + i], ex_a[i]);
                chk("copy_seq_rw", 32'(log_rw[lsz + i]), 32'(ex_r[i]));
                chk("copy_seq_data", log_data[lsz + i], ex_d[i]);
            end
        end

        // Zero length.
        e0 = en_cycles;
        run_cmd(32'h300, 32'h400, 0);
        chk("len0_done_cycle", 32'(seen_done), 32'd1);
        chk("len0_ready_cycle", 32'(seen_rdy), 32'd2);
        chk("len0_no_enable", 32'(en_cycles - e0), 32'd0);

        // Misaligned source, then misaligned destination.
        e0 = en_cycles;
        run_cmd(32'h102, 32'h200, 2);
        chk("mis_src_err_cycle", 32'(seen_err), 32'd1);
        chk("mis_src_no_done", 32'(seen_done), 32'hFFFF_FFFF);
        run_cmd(32'h100, 32'h201, 2);
        chk("mis_dst_err_cycle", 32'(seen_err), 32'd1);
        chk("mis_no_enable", 32'(en_cycles - e0), 32'd0);

        // Slave that never acknowledges.
        ack_mode = 2;
        e0 = en_cycles;
        run_cmd(32'h100, 32'h200, 2);
        chk("tmo_enable_cycles", 32'(en_cycles - e0), 32'd8);
        chk("tmo_err_cycle", 32'(seen_err), 32'd9);
        chk("tmo_ready_cycle", 32'(seen_rdy), 32'd10);

        // Ack on the last allowed cycle is a success.
        ack_mode = 3;
        lsz = log_addr.size();
        run_cmd(32'h500, 32'h600, 1);
        chk("tmo_edge_no_err", 32'(seen_err), 32'hFFFF_FFFF);
        chk("tmo_edge_done_cycle", 32'(seen_done), 32'd18);
        chk("tmo_edge_n_access", 32'(log_addr.size() - lsz), 32'd2);

        // Address wrap.
        ack_mode = 0;
        lsz = log_addr.size();
        run_cmd(32'hFFFF_FFFC, 32'h10, 2);
        ex_a[0] = 32'hFFFF_FFFC; ex_a[1] = 32'h10; ex_a[2] = 32'h0; ex_a[3] = 32'h14;
        chk("wrap_n_access", 32'(log_addr.size() - lsz), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (lsz + i < log_addr.size()) chk("wrap_addr", log_addr[lsz + i], ex_a[i]);
        end
        chk("wrap_mem0", mem[32'h10], init_val(32'hFFFF_FFFC));
        chk("wrap_mem1", mem[32'h14], init_val(32'h0));

        // Reset in the middle of a write access.
        ack_mode = 1;
        start_cmd(32'h100, 32'h700, 5);
        r = 0;
        while (!(bus_bus_enable && !bus_rw) && r < 200) begin
            @(posedge clk); #2;
            r++;
        end
        chk("reach_write", 32'(r < 200), 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_ready", 32'(cmd_ready), 32'd1);
            chk("post_rst_done", 32'({done, error}), 32'd0);
            @(posedge clk); #2;
        end

        // Randomized commands with a mixed-latency slave.
        ack_mode = 4;
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            rs = 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
            rd = 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
            if (r == 0) rs[1:0] = 2'($urandom_range(1, 3));
            if (r == 1) rd[0] = 1'b1;
            if (r == 2) rs = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            run_cmd(rs, rd, LW'($urandom_range(0, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
